// File: rtl/fpu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// fpu_seq_ctrl
//
// Sequencer for the single-precision FPU datapath. The block owns the
// 32-entry FP register array read selects and the EXU start and operation
// controls. It accepts one OP-FP instruction at a time from the integer core.
//
// At acceptance the instruction is decoded and its rounding mode is resolved
// against the dynamic frm field of fcsr. A legal instruction then walks
// READ -> EXEC -> WB. An illegal instruction, or one whose EXU never answers,
// finishes through ERR. ERR signals done and illegal together and writes
// nothing.
//
// Ports
//   clk          in   system clock, rising edge
//   resetn       in   asynchronous active-low reset
//   issue_valid  in   core presents an instruction
//   issue_ready  out  controller can accept (IDLE only)
//   instr        in   32-bit RISC-V instruction word
//   frm          in   dynamic rounding mode, fcsr[7:5]
//   fflags_clr   in   clear accumulated flags (CSR write)
//   rs1_sel      out  register array read select A
//   rs2_sel      out  register array read select B
//   exu_start    out  one-cycle EXU start pulse
//   exu_op       out  EXU operation, instr[31:27]
//   exu_rm       out  resolved rounding mode, or raw funct3 for FSGNJ/FMINMAX
//   exu_done     in   EXU result valid
//   exu_flags    in   EXU exception flags {NV,DZ,OF,UF,NX}, valid with exu_done
//   F_in         out  one-hot register write enable (WB only)
//   done         out  one-cycle completion pulse
//   illegal      out  one-cycle pulse alongside done on reject/abort
//   fflags       out  sticky accumulated flags {NV,DZ,OF,UF,NX}
//
// Parameters
//   FLEN     FP register width; the control paths are fixed at 32 bits.
//   TIMEOUT  maximum EXEC cycles waited for exu_done (must be >= 2)
// -----------------------------------------------------------------------------
module fpu_seq_ctrl #(
    parameter int FLEN    = 32,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [31:0] instr,
    input  logic [2:0]  frm,
    input  logic        fflags_clr,
    output logic [4:0]  rs1_sel,
    output logic [4:0]  rs2_sel,
    output logic        exu_start,
    output logic [4:0]  exu_op,
    output logic [2:0]  exu_rm,
    input  logic        exu_done,
    input  logic [4:0]  exu_flags,
    output logic [31:0] F_in,
    output logic        done,
    output logic        illegal,
    output logic [4:0]  fflags
);

    localparam int NREGS = 32;
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    // The datapath is single precision only. Other widths need no extra control
    // logic, so this branch intentionally builds nothing.
    generate
        if (FLEN != 32) begin : g_flen_other
        end
    endgenerate

    localparam logic [6:0] OPC_OP_FP = 7'b1010011;

    // funct7[6:2] operation codes understood by the EXU
    localparam logic [4:0] F5_FADD   = 5'b00000;
    localparam logic [4:0] F5_FSUB   = 5'b00001;
    localparam logic [4:0] F5_FMUL   = 5'b00010;
    localparam logic [4:0] F5_FDIV   = 5'b00011;
    localparam logic [4:0] F5_FSGNJ  = 5'b00100;
    localparam logic [4:0] F5_FMINMX = 5'b00101;
    localparam logic [4:0] F5_FSQRT  = 5'b01011;

    localparam logic [2:0] RM_DYN = 3'b111;
    localparam logic [2:0] RM_MAX = 3'b100;   // highest defined static mode (RMM)

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB,
        S_ERR
    } state_t;

    state_t           state_reg,   state_next;
    logic [CNT_W-1:0] counter_reg, counter_next;
    logic [4:0]       rs1_reg,     rs1_next;
    logic [4:0]       rs2_reg,     rs2_next;
    logic [4:0]       rd_reg,      rd_next;
    logic [4:0]       op_reg,      op_next;
    logic [2:0]       rm_reg,      rm_next;
    logic [4:0]       cap_reg,     cap_next;     // exu_flags seen at exu_done
    logic [4:0]       fflags_reg,  fflags_next;

    // ------------------------------------------------------------------
    // Decode of the presented instruction word. This is evaluated every
    // cycle but only matters in the cycle the instruction is accepted.
    // ------------------------------------------------------------------
    logic [6:0] dec_opcode;
    logic [4:0] dec_f5;
    logic [1:0] dec_fmt;
    logic [4:0] dec_rs2;
    logic [2:0] dec_f3;
    logic       dec_is_arith;
    logic       dec_op_ok;
    logic       dec_rm_ok;
    logic [2:0] dec_rm;
    logic       dec_legal;

    assign dec_opcode = instr[6:0];
    assign dec_f5     = instr[31:27];
    assign dec_fmt    = instr[26:25];
    assign dec_rs2    = instr[24:20];
    assign dec_f3     = instr[14:12];

    always_comb begin
        dec_is_arith = 1'b0;
        dec_op_ok    = 1'b0;
        unique case (dec_f5)
            F5_FADD, F5_FSUB, F5_FMUL, F5_FDIV: begin
                dec_is_arith = 1'b1;
                dec_op_ok    = 1'b1;
            end
            F5_FSQRT: begin
                // Unary op: the rs2 field is reserved and must be zero.
                dec_is_arith = 1'b1;
                dec_op_ok    = (dec_rs2 == 5'd0);
            end
            F5_FSGNJ:  dec_op_ok = (dec_f3 <= 3'b010);  // FSGNJ/FSGNJN/FSGNJX
            F5_FMINMX: dec_op_ok = (dec_f3 <= 3'b001);  // FMIN/FMAX
            default:   dec_op_ok = 1'b0;
        endcase
    end

    // Rounding resolution. For sign-inject and min/max, funct3 selects the
    // sub-operation rather than a rounding mode. In that case it goes to the
    // EXU unchanged, and frm is not consulted.
    always_comb begin
        dec_rm    = dec_f3;
        dec_rm_ok = 1'b1;
        if (dec_is_arith) begin
            if (dec_f3 == RM_DYN) begin
                dec_rm    = frm;
                dec_rm_ok = (frm <= RM_MAX);
            end else begin
                dec_rm_ok = (dec_f3 <= RM_MAX);
            end
        end
    end

    assign dec_legal = (dec_opcode == OPC_OP_FP) && (dec_fmt == 2'b00)
                       && dec_op_ok && dec_rm_ok;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= S_IDLE;
            counter_reg <= '0;
            rs1_reg     <= '0;
            rs2_reg     <= '0;
            rd_reg      <= '0;
            op_reg      <= '0;
            rm_reg      <= '0;
            cap_reg     <= '0;
            fflags_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            counter_reg <= counter_next;
            rs1_reg     <= rs1_next;
            rs2_reg     <= rs2_next;
            rd_reg      <= rd_next;
            op_reg      <= op_next;
            rm_reg      <= rm_next;
            cap_reg     <= cap_next;
            fflags_reg  <= fflags_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    logic wb_active;

    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg;
        rs1_next     = rs1_reg;
        rs2_next     = rs2_reg;
        rd_next      = rd_reg;
        op_next      = op_reg;
        rm_next      = rm_reg;
        cap_next     = cap_reg;
        fflags_next  = fflags_clr ? 5'd0 : fflags_reg;

        issue_ready  = 1'b0;
        rs1_sel      = 5'd0;
        rs2_sel      = 5'd0;
        exu_start    = 1'b0;
        exu_op       = 5'd0;
        exu_rm       = 3'd0;
        wb_active    = 1'b0;
        done         = 1'b0;
        illegal      = 1'b0;

        unique case (state_reg)
            S_IDLE: begin
                issue_ready = 1'b1;
                if (issue_valid) begin
                    rs1_next   = instr[19:15];
                    rs2_next   = instr[24:20];
                    rd_next    = instr[11:7];
                    op_next    = dec_f5;
                    rm_next    = dec_rm;
                    state_next = dec_legal ? S_READ : S_ERR;
                end
            end

            S_READ: begin
                rs1_sel      = rs1_reg;
                rs2_sel      = rs2_reg;
                exu_op       = op_reg;
                exu_rm       = rm_reg;
                counter_next = '0;
                state_next   = S_EXEC;
            end

            S_EXEC: begin
                rs1_sel   = rs1_reg;
                rs2_sel   = rs2_reg;
                exu_op    = op_reg;
                exu_rm    = rm_reg;
                // The counter is zero only in the first EXEC cycle, because it
                // saturates and does not wrap.
                exu_start = (counter_reg == '0);
                if (counter_reg != CNT_LAST) begin
                    counter_next = counter_reg + 1'b1;
                end
                // A result arriving in the last allowed cycle still counts.
                if (exu_done) begin
                    cap_next   = exu_flags;
                    state_next = S_WB;
                end else if (counter_reg == CNT_LAST) begin
                    state_next = S_ERR;
                end
            end

            S_WB: begin
                wb_active  = 1'b1;
                done       = 1'b1;
                // A CSR clear in this cycle is applied first, so the new flags survive.
                fflags_next = (fflags_clr ? 5'd0 : fflags_reg) | cap_reg;
                state_next  = S_IDLE;
            end

            S_ERR: begin
                done       = 1'b1;
                illegal    = 1'b1;
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // One-hot register write enable: bit gi fires only in WB when rd selects it.
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_f_in
            assign F_in[gi] = wb_active && (rd_reg == 5'(gi));
        end
    endgenerate

    assign fflags = fflags_reg;

endmodule

// File: tb/tb_fpu_seq_ctrl.sv
module tb_fpu_seq_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] instr;
    logic [2:0]  frm;
    logic        fflags_clr;
    logic [4:0]  rs1_sel;
    logic [4:0]  rs2_sel;
    logic        exu_start;
    logic [4:0]  exu_op;
    logic [2:0]  exu_rm;
    logic        exu_done;
    logic [4:0]  exu_flags;
    logic [31:0] F_in;
    logic        done;
    logic        illegal;
    logic [4:0]  fflags;

    int vectors     = 0;
    int miscompares = 0;

    fpu_seq_ctrl #(.FLEN(32), .TIMEOUT(64)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .instr       (instr),
        .frm         (frm),
        .fflags_clr  (fflags_clr),
        .rs1_sel     (rs1_sel),
        .rs2_sel     (rs2_sel),
        .exu_start   (exu_start),
        .exu_op      (exu_op),
        .exu_rm      (exu_rm),
        .exu_done    (exu_done),
        .exu_flags   (exu_flags),
        .F_in        (F_in),
        .done        (done),
        .illegal     (illegal),
        .fflags      (fflags)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] op_fp(input logic [4:0] f5, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f5, 2'b00, rs2, rs1, f3, rd, 7'b1010011};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Present a word in IDLE for one edge. Returns in the cycle after acceptance.
    task automatic issue(input logic [31:0] w);
        issue_valid = 1'b1;
        instr       = w;
        tick();
        issue_valid = 1'b0;
    endtask

    // Rejected instruction: ERR in the cycle after acceptance, then IDLE.
    task automatic expect_reject(input string tag);
        chk({tag, "_done"},    done,      1'b1);
        chk({tag, "_illegal"}, illegal,   1'b1);
        chk({tag, "_f_in"},    F_in,      32'h0);
        chk({tag, "_start"},   exu_start, 1'b0);
        tick();
        chk({tag, "_ready"},   issue_ready, 1'b1);
        chk({tag, "_ill_end"}, illegal,     1'b0);
    endtask

    logic [31:0] w;

    initial begin
        resetn      = 1'b0;
        issue_valid = 1'b0;
        instr       = 32'h0;
        frm         = 3'b000;
        fflags_clr  = 1'b0;
        exu_done    = 1'b0;
        exu_flags   = 5'd0;

        // ---------------- reset state ----------------
        tick();
        chk("rst_ready",  issue_ready, 1'b1);
        chk("rst_done",   done,        1'b0);
        chk("rst_ill",    illegal,     1'b0);
        chk("rst_f_in",   F_in,        32'h0);
        chk("rst_fflags", fflags,      5'd0);
        chk("rst_start",  exu_start,   1'b0);
        resetn = 1'b1;
        tick();

        // ---------------- FADD f5 = f3 + f4, rm=RNE ----------------
        $display("txn FADD rs1=3 rs2=4 rd=5 rm=000 flags=00001");
        issue(op_fp(5'b00000, 5'd4, 5'd3, 3'b000, 5'd5));       // cycle 1
        chk("fadd_rs1",     rs1_sel,     5'd3);
        chk("fadd_rs2",     rs2_sel,     5'd4);
        chk("fadd_rd_st",   exu_start,   1'b0);
        chk("fadd_busy",    issue_ready, 1'b0);
        tick();                                                   // cycle 2
        chk("fadd_start",   exu_start,   1'b1);
        chk("fadd_rm",      exu_rm,      3'b000);
        chk("fadd_op",      exu_op,      5'b00000);
        tick();                                                   // cycle 3
        chk("fadd_start1",  exu_start,   1'b0);
        chk("fadd_rs1_hold", rs1_sel,    5'd3);
        tick();                                                   // cycle 4
        exu_done = 1'b1; exu_flags = 5'b00001;
        chk("fadd_nodone",  done,        1'b0);
        tick();                                                   // cycle 5
        exu_done = 1'b0; exu_flags = 5'd0;
        chk("fadd_done",    done,        1'b1);
        chk("fadd_f_in",    F_in,        32'h0000_0020);
        chk("fadd_ill",     illegal,     1'b0);
        tick();
        chk("fadd_fflags",  fflags,      5'b00001);
        chk("fadd_done_end", done,       1'b0);
        chk("fadd_f_in_end", F_in,       32'h0);
        chk("fadd_ready",   issue_ready, 1'b1);

        // ---------------- FSUB with clear in WB, then back-to-back ----------------
        $display("txn FSUB rd=7 flags=10000 with fflags_clr in WB");
        issue(op_fp(5'b00001, 5'd2, 5'd1, 3'b000, 5'd7));       // cycle 1
        tick();                                                   // cycle 2
        chk("fsub_start",   exu_start,   1'b1);
        exu_done = 1'b1; exu_flags = 5'b10000;
        tick();                                                   // cycle 3 (WB)
        exu_done = 1'b0; exu_flags = 5'd0;
        fflags_clr = 1'b1;
        chk("fsub_done",    done,        1'b1);
        chk("fsub_f_in",    F_in,        32'h0000_0080);
        tick();                                                   // cycle 4 (IDLE)
        fflags_clr = 1'b0;
        chk("fsub_fflags",  fflags,      5'b10000);
        chk("fsub_ready",   issue_ready, 1'b1);
        $display("txn FADD rs1=8 rs2=9 rd=10 rm=001 back-to-back flags=00100");
        issue(op_fp(5'b00000, 5'd9, 5'd8, 3'b001, 5'd10));      // accepted at once
        chk("b2b_rs1",      rs1_sel,     5'd8);
        chk("b2b_busy",     issue_ready, 1'b0);
        tick();
        chk("b2b_start",    exu_start,   1'b1);
        chk("b2b_rm",       exu_rm,      3'b001);
        exu_done = 1'b1; exu_flags = 5'b00100;
        tick();
        exu_done = 1'b0; exu_flags = 5'd0;
        chk("b2b_done",     done,        1'b1);
        chk("b2b_f_in",     F_in,        32'h0000_0400);
        tick();
        chk("b2b_fflags",   fflags,      5'b10100);

        // ---------------- FMUL dynamic rm, frm=RDN, rd=f0 ----------------
        $display("txn FMUL rm=111 frm=010 rd=0");
        frm = 3'b010;
        issue(op_fp(5'b00010, 5'd6, 5'd5, 3'b111, 5'd0));
        tick();
        chk("fmul_start",   exu_start,   1'b1);
        chk("fmul_rm",      exu_rm,      3'b010);
        chk("fmul_op",      exu_op,      5'b00010);
        exu_done = 1'b1;
        tick();
        exu_done = 1'b0;
        chk("fmul_done",    done,        1'b1);
        chk("fmul_f_in",    F_in,        32'h0000_0001);
        tick();
        chk("fmul_ready",   issue_ready, 1'b1);
        chk("fmul_fflags",  fflags,      5'b10100);

        // ---------------- rejected instructions ----------------
        $display("txn FMUL rm=111 frm=101 -> reject");
        frm = 3'b101;
        issue(op_fp(5'b00010, 5'd6, 5'd5, 3'b111, 5'd1));
        expect_reject("fmul_badfrm");

        $display("txn FSQRT rs2=1 -> reject");
        issue(op_fp(5'b01011, 5'd1, 5'd2, 3'b000, 5'd3));
        expect_reject("fsqrt_rs2");

        $display("txn opcode 0000011 -> reject");
        w = op_fp(5'b00000, 5'd2, 5'd1, 3'b000, 5'd3);
        w[6:0] = 7'b0000011;
        issue(w);
        expect_reject("bad_opcode");

        $display("txn FMIN funct3=010 -> reject");
        issue(op_fp(5'b00101, 5'd2, 5'd1, 3'b010, 5'd4));
        expect_reject("fmin_f3");

        $display("txn FADD rm=101 -> reject");
        issue(op_fp(5'b00000, 5'd2, 5'd1, 3'b101, 5'd4));
        expect_reject("fadd_rm101");

        $display("txn FADD fmt=01 -> reject");
        w = op_fp(5'b00000, 5'd2, 5'd1, 3'b000, 5'd4);
        w[25] = 1'b1;
        issue(w);
        expect_reject("fadd_fmt");

        // ---------------- FSGNJX: funct3 passes through, frm ignored ----------------
        $display("txn FSGNJX funct3=010 rd=4 (frm=101 unused)");
        issue(op_fp(5'b00100, 5'd2, 5'd1, 3'b010, 5'd4));
        chk("fsgnj_legal",  illegal,     1'b0);
        tick();
        chk("fsgnj_start",  exu_start,   1'b1);
        chk("fsgnj_rm",     exu_rm,      3'b010);
        chk("fsgnj_op",     exu_op,      5'b00100);
        exu_done = 1'b1;
        tick();
        exu_done = 1'b0;
        chk("fsgnj_done",   done,        1'b1);
        chk("fsgnj_f_in",   F_in,        32'h0000_0010);
        tick();

        // ---------------- FDIV timeout ----------------
        $display("txn FDIV no exu_done -> timeout after 64 EXEC cycles");
        frm = 3'b000;
        issue(op_fp(5'b00011, 5'd2, 5'd1, 3'b000, 5'd6));       // cycle 1
        tick();                                                   // cycle 2, EXEC #1
        chk("tmo_start",    exu_start,   1'b1);
        repeat (63) tick();                                       // cycle 65, EXEC #64
        chk("tmo_last_done", done,       1'b0);
        chk("tmo_last_busy", issue_ready, 1'b0);
        chk("tmo_last_st",  exu_start,   1'b0);
        tick();                                                   // cycle 66, ERR
        chk("tmo_done",     done,        1'b1);
        chk("tmo_ill",      illegal,     1'b1);
        chk("tmo_f_in",     F_in,        32'h0);
        exu_done = 1'b1; exu_flags = 5'b11111;                    // late answer
        tick();
        chk("tmo_ready",    issue_ready, 1'b1);
        chk("tmo_late_done", done,       1'b0);
        tick();
        exu_done = 1'b0; exu_flags = 5'd0;
        chk("tmo_late_wb",  done,        1'b0);
        chk("tmo_fflags",   fflags,      5'b10100);

        // ---------------- fflags_clr in IDLE ----------------
        $display("txn fflags_clr");
        fflags_clr = 1'b1;
        tick();
        fflags_clr = 1'b0;
        chk("clr_fflags",   fflags,      5'd0);

        // ---------------- FADD to f31 ----------------
        $display("txn FADD rd=31 flags=00010");
        issue(op_fp(5'b00000, 5'd2, 5'd1, 3'b000, 5'd31));
        tick();
        exu_done = 1'b1; exu_flags = 5'b00010;
        tick();
        exu_done = 1'b0; exu_flags = 5'd0;
        chk("f31_f_in",     F_in,        32'h8000_0000);
        tick();
        chk("f31_fflags",   fflags,      5'b00010);

        // ---------------- reset mid-EXEC ----------------
        $display("txn FDIV abandoned by reset in EXEC");
        issue(op_fp(5'b00011, 5'd2, 5'd1, 3'b000, 5'd6));
        tick();
        tick();
        resetn = 1'b0;
        #1;
        chk("mrst_ready",   issue_ready, 1'b1);
        chk("mrst_f_in",    F_in,        32'h0);
        chk("mrst_fflags",  fflags,      5'd0);
        chk("mrst_done",    done,        1'b0);
        chk("mrst_start",   exu_start,   1'b0);
        tick();
        resetn = 1'b1;
        tick();
        chk("mrst_no_done", done,        1'b0);

        $display("txn FMUL after reset rm=111 frm=010 rd=9 flags=00001");
        frm = 3'b010;
        issue(op_fp(5'b00010, 5'd2, 5'd1, 3'b111, 5'd9));
        tick();
        chk("post_start",   exu_start,   1'b1);
        chk("post_rm",      exu_rm,      3'b010);
        exu_done = 1'b1; exu_flags = 5'b00001;
        tick();
        exu_done = 1'b0; exu_flags = 5'd0;
        chk("post_done",    done,        1'b1);
        chk("post_f_in",    F_in,        32'h0000_0200);
        tick();
        chk("post_fflags",  fflags,      5'b00001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
